// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the memory stage and the load/store lane aligner.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_e;

  // Halfword accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if ((funct3 == F3_H) || (funct3 == F3_HU)) begin
      bad = offset[0];
    end else if (funct3 == F3_W) begin
      bad = (offset != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_be_o,
    output dmem_wdata_o,
    input  dmem_ack_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_be_o,
    input  dmem_wdata_o,
    output dmem_ack_i,
    output dmem_rdata_i
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data/enables out to the word bus, and
// extraction plus sign/zero extension of load data coming back.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Sub-word stores replicate the datum across all lanes; be selects the live lane.
  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        be    = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      F3_W: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h000000, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0000, shifted[15:0]};
      F3_W:    load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: issues data-memory accesses over req/ack, stalls upstream while one is
// outstanding, and loads the MEM/WB pipeline registers.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] RegReadData2,
  input  logic [31:0] instMEM,
  mem_stage_if.master dmem,
  output logic        stall_o,
  output logic [31:0] PC_reg,
  output logic [31:0] ALUOut_reg,
  output logic [31:0] MemData_reg,
  output logic [31:0] inst_reg,
  output logic        valid_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e state, state_next;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic        is_load, is_store, mem_op, misaligned;
  logic        start, capture, timeout;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_load;

  logic             req_q, we_q, err_q;
  logic [31:0]      addr_q, wdata_q, load_buf;
  logic [3:0]       be_q;
  logic [CNT_W-1:0] cnt;

  assign opcode     = instMEM[6:0];
  assign funct3     = instMEM[14:12];
  assign offset     = ALUOut[1:0];
  assign is_load    = (opcode == OP_LOAD);
  assign is_store   = (opcode == OP_STORE);
  assign mem_op     = valid_i & (is_load | is_store);
  assign misaligned = is_misaligned(funct3, offset);

  lsu_align u_align (
    .funct3     (funct3),
    .offset     (offset),
    .store_data (RegReadData2),
    .rdata      (dmem.dmem_rdata_i),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An ack in the same cycle as the last allowed REQ cycle still wins over the timeout.
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    start      = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          start      = 1'b1;
          stall_o    = 1'b1;
          state_next = REQ;
        end else begin
          capture = 1'b1;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem.dmem_ack_i) begin
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst_i) begin
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      load_buf <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_q    <= 1'b1;
            we_q     <= is_store;
            addr_q   <= {ALUOut[31:2], 2'b00};
            be_q     <= is_store ? align_be : 4'b1111;
            wdata_q  <= is_store ? align_wdata : 32'h0;
            cnt      <= '0;
            load_buf <= '0;
            err_q    <= 1'b0;
          end
        end
        REQ: begin
          if (dmem.dmem_ack_i) begin
            req_q    <= 1'b0;
            load_buf <= we_q ? 32'h0 : align_load;
          end else if (timeout) begin
            req_q    <= 1'b0;
            err_q    <= 1'b1;
            load_buf <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_be_o    = be_q;
  assign dmem.dmem_wdata_o = wdata_q;

  // While an access is in flight the WB stage sees a bubble rather than a repeat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      PC_reg      <= '0;
      ALUOut_reg  <= '0;
      MemData_reg <= '0;
      inst_reg    <= '0;
      valid_o     <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else if (capture) begin
      PC_reg     <= PC;
      ALUOut_reg <= ALUOut;
      inst_reg   <= instMEM;
      valid_o    <= valid_i;
      if (state == DONE) begin
        MemData_reg <= load_buf;
        misalign_o  <= 1'b0;
        bus_err_o   <= err_q;
      end else begin
        MemData_reg <= '0;
        misalign_o  <= mem_op & misaligned;
        bus_err_o   <= 1'b0;
      end
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized ops against a
// behavioural model, and hand-written reset / late-ack sequences.
module tb_mem_stage;
  import riscv_pkg::*;

  localparam int TIMEOUT = 4;

  typedef struct {
    logic        issue;
    int          stallCycles;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] memData;
    logic        misalign;
    logic        busErr;
  } expect_t;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] p;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] i;
    logic [31:0] rd;
    int          ackDelay;
    expect_t     e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] pc = '0, alu = '0, rs2 = '0, inst = '0;
  logic        stall, validOut, misalign, busErr;
  logic [31:0] pcReg, aluReg, memReg, instReg;

  int checks = 0;
  int failures = 0;

  int          obsStall, obsReq;
  logic        obsWe;
  logic [31:0] obsAddr, obsWdata;
  logic [3:0]  obsBe;
  bit          obsDone;

  vec_t vecs[$];

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid),
    .PC           (pc),
    .ALUOut       (alu),
    .RegReadData2 (rs2),
    .instMEM      (inst),
    .dmem         (dmem),
    .stall_o      (stall),
    .PC_reg       (pcReg),
    .ALUOut_reg   (aluReg),
    .MemData_reg  (memReg),
    .inst_reg     (instReg),
    .valid_o      (validOut),
    .misalign_o   (misalign),
    .bus_err_o    (busErr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mkInst(input logic [6:0] op, input logic [2:0] f3);
    return {12'h000, 5'd2, f3, 5'd5, op};
  endfunction

  function automatic expect_t mkExp(input logic issue, input int st, input logic we,
                                    input logic [31:0] addr, input logic [3:0] be,
                                    input logic [31:0] wdata, input logic [31:0] md,
                                    input logic mis, input logic err);
    expect_t e;
    e.issue = issue; e.stallCycles = st; e.we = we; e.addr = addr; e.be = be;
    e.wdata = wdata; e.memData = md; e.misalign = mis; e.busErr = err;
    return e;
  endfunction

  // Reference model computed straight from the ISA rules with plain arithmetic.
  function automatic expect_t refModel(input logic v, input logic [31:0] a, input logic [31:0] d,
                                       input logic [31:0] i, input logic [31:0] rd,
                                       input int ackDelay);
    expect_t     e;
    int          f3, off;
    logic        isStore, isMem, bad;
    logic [31:0] w, b, h;
    e = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    f3 = int'(i[14:12]);
    off = int'(a[1:0]);
    isStore = (i[6:0] == 7'h23);
    isMem = v && (isStore || (i[6:0] == 7'h03));
    bad = (((f3 == 1) || (f3 == 5)) && (off % 2 == 1)) || ((f3 == 2) && (off != 0));
    if (isMem && bad) begin
      e.misalign = 1'b1;
    end else if (isMem) begin
      e.issue = 1'b1;
      e.we = isStore;
      e.addr = a - 32'(off);
      if ((ackDelay >= 0) && (ackDelay < TIMEOUT)) begin
        e.stallCycles = 2 + ackDelay;
      end else begin
        e.stallCycles = 1 + TIMEOUT;
        e.busErr = 1'b1;
      end
      if (isStore) begin
        if (f3 == 0) begin
          e.be = 4'(1 << off);
          e.wdata = (d % 256) * 32'h01010101;
        end else if (f3 == 1) begin
          e.be = 4'(3 << off);
          e.wdata = (d % 65536) * 32'h00010001;
        end else begin
          e.be = 4'hF;
          e.wdata = d;
        end
      end else begin
        e.be = 4'hF;
        if (!e.busErr) begin
          w = rd / (32'd1 << (8 * off));
          b = w % 256;
          h = w % 65536;
          case (f3)
            0: e.memData = (b >= 128) ? b - 256 : b;
            4: e.memData = b;
            1: e.memData = (h >= 32768) ? h - 65536 : h;
            5: e.memData = h;
            2: e.memData = rd;
            default: e.memData = 0;
          endcase
        end
      end
    end
    return e;
  endfunction

  task automatic addVec(input string name, input logic v, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] i, input logic [31:0] rd,
                        input int ackDelay, input expect_t e);
    vec_t t;
    t.name = name; t.v = v; t.p = p; t.a = a; t.d = d; t.i = i; t.rd = rd;
    t.ackDelay = ackDelay; t.e = e;
    vecs.push_back(t);
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Presents one instruction and plays the memory until the MEM/WB registers capture it.
  task automatic applyStimulus(input logic v, input logic [31:0] p, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] i,
                               input logic [31:0] rd, input int ackDelay);
    int waited;
    waited = 0;
    valid = v; pc = p; alu = a; rs2 = d; inst = i;
    dmem.dmem_ack_i = 1'b0;
    dmem.dmem_rdata_i = $urandom;
    obsStall = 0; obsReq = 0; obsWe = 1'b0; obsAddr = '0; obsWdata = '0; obsBe = '0;
    obsDone = 1'b0;
    for (int c = 0; (c < 40) && !obsDone; c++) begin
      #1;
      if (stall === 1'b1) obsStall++;
      if (dmem.dmem_req_o === 1'b1) begin
        obsReq++;
        obsWe = dmem.dmem_we_o;
        obsAddr = dmem.dmem_addr_o;
        obsBe = dmem.dmem_be_o;
        obsWdata = dmem.dmem_wdata_o;
        if ((ackDelay >= 0) && (waited == ackDelay)) begin
          dmem.dmem_ack_i = 1'b1;
          dmem.dmem_rdata_i = rd;
        end
        waited++;
      end
      if (stall !== 1'b1) obsDone = 1'b1;
      @(posedge clk);
      #1;
      dmem.dmem_ack_i = 1'b0;
      dmem.dmem_rdata_i = $urandom;
    end
  endtask

  task automatic checkOutput(input string name, input expect_t e, input logic v,
                             input logic [31:0] p, input logic [31:0] a, input logic [31:0] i);
    if (!obsDone) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.capture actual=none required=capture within 40 cycles", name);
      return;
    end
    checkValue({name, ".stallCycles"}, 32'(obsStall), 32'(e.stallCycles));
    checkValue({name, ".reqCycles"}, 32'(obsReq), e.issue ? 32'(e.stallCycles - 1) : 32'h0);
    checkValue({name, ".PC_reg"}, pcReg, p);
    checkValue({name, ".ALUOut_reg"}, aluReg, a);
    checkValue({name, ".inst_reg"}, instReg, i);
    checkValue({name, ".MemData_reg"}, memReg, e.memData);
    checkValue({name, ".valid_o"}, {31'h0, validOut}, {31'h0, v});
    checkValue({name, ".misalign_o"}, {31'h0, misalign}, {31'h0, e.misalign});
    checkValue({name, ".bus_err_o"}, {31'h0, busErr}, {31'h0, e.busErr});
    if (e.issue) begin
      checkValue({name, ".dmem_addr_o"}, obsAddr, e.addr);
      checkValue({name, ".dmem_we_o"}, {31'h0, obsWe}, {31'h0, e.we});
      checkValue({name, ".dmem_be_o"}, {28'h0, obsBe}, {28'h0, e.be});
      if (e.we) checkValue({name, ".dmem_wdata_o"}, obsWdata, e.wdata);
    end
  endtask

  initial begin
    logic [31:0] rInst, rAlu, rData, rRd, rPc;
    logic        rValid;
    int          kind, rDelay;
    expect_t     rExp;

    dmem.dmem_ack_i = 1'b0;
    dmem.dmem_rdata_i = '0;

    addVec("add", 1, 32'h100, 32'h10, 32'h0, mkInst(7'b0110011, 3'b000), 32'h0, 0,
           mkExp(0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    addVec("lb", 1, 32'h104, 32'h1003, 32'h0, mkInst(OP_LOAD, F3_B), 32'h80FF_0000, 2,
           mkExp(1, 4, 0, 32'h1000, 4'hF, 0, 32'hFFFF_FF80, 0, 0));
    addVec("lbu", 1, 32'h108, 32'h1003, 32'h0, mkInst(OP_LOAD, F3_BU), 32'h80FF_0000, 2,
           mkExp(1, 4, 0, 32'h1000, 4'hF, 0, 32'h0000_0080, 0, 0));
    addVec("sh", 1, 32'h10C, 32'h2002, 32'h1234_ABCD, mkInst(OP_STORE, F3_H), 32'h0, 0,
           mkExp(1, 2, 1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0));
    addVec("lwMisaligned", 1, 32'h110, 32'h3001, 32'h0, mkInst(OP_LOAD, F3_W), 32'h0, 0,
           mkExp(0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
    addVec("lh", 1, 32'h114, 32'h1002, 32'h0, mkInst(OP_LOAD, F3_H), 32'h8001_1234, 1,
           mkExp(1, 3, 0, 32'h1000, 4'hF, 0, 32'hFFFF_8001, 0, 0));
    addVec("sbLastCycleAck", 1, 32'h118, 32'h5001, 32'h0000_0055, mkInst(OP_STORE, F3_B), 32'h0, 3,
           mkExp(1, 5, 1, 32'h5000, 4'b0010, 32'h5555_5555, 32'h0, 0, 0));
    addVec("lwTimeout", 1, 32'h11C, 32'h4000, 32'h0, mkInst(OP_LOAD, F3_W), 32'hDEAD_BEEF, -1,
           mkExp(1, 5, 0, 32'h4000, 4'hF, 0, 32'h0, 0, 1));

    #2;
    checkValue("reset.dmem_req_o", {31'h0, dmem.dmem_req_o}, 32'h0);
    checkValue("reset.stall_o", {31'h0, stall}, 32'h0);
    checkValue("reset.PC_reg", pcReg, 32'h0);
    checkValue("reset.MemData_reg", memReg, 32'h0);
    checkValue("reset.valid_o", {31'h0, validOut}, 32'h0);
    checkValue("reset.bus_err_o", {31'h0, busErr}, 32'h0);
    dmem.dmem_ack_i = 1'b1;
    @(posedge clk);
    #1;
    dmem.dmem_ack_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].v, vecs[k].p, vecs[k].a, vecs[k].d, vecs[k].i, vecs[k].rd, vecs[k].ackDelay);
      checkOutput(vecs[k].name, vecs[k].e, vecs[k].v, vecs[k].p, vecs[k].a, vecs[k].i);
    end

    // A stray ack right after a timeout, while idle, must change nothing.
    valid = 1'b1; pc = 32'h300; alu = 32'h77; inst = mkInst(7'b0110011, 3'b000);
    dmem.dmem_ack_i = 1'b1;
    dmem.dmem_rdata_i = 32'hFFFF_FFFF;
    #1;
    checkValue("lateAck.stall_o", {31'h0, stall}, 32'h0);
    checkValue("lateAck.dmem_req_o", {31'h0, dmem.dmem_req_o}, 32'h0);
    @(posedge clk);
    #1;
    dmem.dmem_ack_i = 1'b0;
    checkValue("lateAck.dmem_req_o2", {31'h0, dmem.dmem_req_o}, 32'h0);
    checkValue("lateAck.bus_err_o", {31'h0, busErr}, 32'h0);
    checkValue("lateAck.MemData_reg", memReg, 32'h0);
    checkValue("lateAck.ALUOut_reg", aluReg, 32'h77);
    checkValue("lateAck.valid_o", {31'h0, validOut}, 32'h1);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      rInst = $urandom;
      if (kind <= 3) begin
        rInst[6:0] = OP_LOAD;
        rInst[14:12] = 3'($urandom_range(0, 7));
      end else if (kind <= 6) begin
        rInst[6:0] = OP_STORE;
        rInst[14:12] = 3'($urandom_range(0, 2));
      end else begin
        rInst[6:0] = 7'b0110011;
      end
      rValid = ($urandom_range(0, 7) != 0);
      rAlu = $urandom;
      rData = $urandom;
      rRd = $urandom;
      rPc = $urandom;
      rDelay = $urandom_range(0, 5);
      if (rDelay == 5) rDelay = -1;
      rExp = refModel(rValid, rAlu, rData, rInst, rRd, rDelay);
      applyStimulus(rValid, rPc, rAlu, rData, rInst, rRd, rDelay);
      checkOutput($sformatf("rand%0d", n), rExp, rValid, rPc, rAlu, rInst);
    end

    // Reset asserted mid-access clears everything at once; a later ack is ignored.
    valid = 1'b1; pc = 32'h400; alu = 32'h40; rs2 = 32'h0; inst = mkInst(OP_LOAD, F3_W);
    @(posedge clk);
    #1;
    checkValue("midReset.reqBefore", {31'h0, dmem.dmem_req_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkValue("midReset.dmem_req_o", {31'h0, dmem.dmem_req_o}, 32'h0);
    checkValue("midReset.stall_o", {31'h0, stall}, 32'h0);
    checkValue("midReset.PC_reg", pcReg, 32'h0);
    checkValue("midReset.ALUOut_reg", aluReg, 32'h0);
    checkValue("midReset.inst_reg", instReg, 32'h0);
    checkValue("midReset.valid_o", {31'h0, validOut}, 32'h0);
    valid = 1'b0;
    dmem.dmem_ack_i = 1'b1;
    dmem.dmem_rdata_i = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkValue("postReset.stall_o", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    dmem.dmem_ack_i = 1'b0;
    checkValue("postReset.dmem_req_o", {31'h0, dmem.dmem_req_o}, 32'h0);
    checkValue("postReset.MemData_reg", memReg, 32'h0);
    checkValue("postReset.bus_err_o", {31'h0, busErr}, 32'h0);
    checkValue("postReset.valid_o", {31'h0, validOut}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
